// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
//
// Purpose:
//    Traffic-light controller for a two-road intersection. NS is the main road:
//    it stays green until a vehicle waits on EW or a pedestrian has pressed the
//    button, and then only after a minimum green time. The cycle is
//    NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2.
//    All timing is in ticks. A tick is one clock cycle in every TICK_DIV
//    cycles, produced by a free-running prescaler.
//
// Ports:
//    clock_100mhz  in   sole clock, rising edge
//    rst           in   synchronous active-high reset
//    sensor_ew     in   EW vehicle present (level, sampled on tick cycles only)
//    ped_req       in   pedestrian button (any high cycle latches a request)
//    ns_light      out  NS lamps one-hot {red, yellow, green}
//    ew_light      out  EW lamps one-hot {red, yellow, green}
//    walk          out  walk signal for crossing NS, shown during EW_GREEN
//    tick          out  one-cycle timing tick (debug)
//    state_o       out  current state code (0..5)
// -----------------------------------------------------------------------------
module intersection_ctrl #(
   parameter int TICK_DIV = 100,
   parameter int T_NS_MIN = 6,
   parameter int T_YEL    = 2,
   parameter int T_AR     = 1,
   parameter int T_EW     = 5
) (
   input  logic       clock_100mhz,
   input  logic       rst,
   input  logic       sensor_ew,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       walk,
   output logic       tick,
   output logic [2:0] state_o
);

   localparam int PW = $clog2(TICK_DIV);

   // The state timer only needs to reach the longest duration minus one.
   localparam int TMAX_A = (T_NS_MIN > T_YEL) ? T_NS_MIN : T_YEL;
   localparam int TMAX_B = (T_AR > T_EW) ? T_AR : T_EW;
   localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int TW     = (TMAX < 2) ? 1 : $clog2(TMAX);

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [TW-1:0] tcnt_q,  tcnt_d;
   logic          pend_q,  pend_d;
   logic          walk_q,  walk_d;

   logic          tick_w;
   logic          enter_ew;
   logic [2:0]    ns_w, ew_w;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock_100mhz) begin
      if (rst) begin
         state_q <= NS_GREEN;
         presc_q <= '0;
         tcnt_q  <= '0;
         pend_q  <= 1'b0;
         walk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         tcnt_q  <= tcnt_d;
         pend_q  <= pend_d;
         walk_q  <= walk_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ns_w     = LAMP_RED;
      ew_w     = LAMP_RED;

      tick_w   = (presc_q == PW'(TICK_DIV - 1));
      presc_d  = tick_w ? '0 : presc_q + PW'(1);

      // Every timed exit is qualified by tick_w, so a state always ends on
      // the edge that closes a tick cycle and lasts a whole number of ticks.
      case (state_q)
         NS_GREEN: begin
            ns_w = LAMP_GRN;
            // sensor_ew only matters on the tick cycle itself; short pulses
            // between ticks are deliberately ignored.
            if (tick_w && (tcnt_q == TW'(T_NS_MIN - 1)) && (sensor_ew || pend_q))
               state_d = NS_YELLOW;
         end
         NS_YELLOW: begin
            ns_w = LAMP_YEL;
            if (tick_w && (tcnt_q == TW'(T_YEL - 1)))
               state_d = ALL_RED_1;
         end
         ALL_RED_1: begin
            if (tick_w && (tcnt_q == TW'(T_AR - 1)))
               state_d = EW_GREEN;
         end
         EW_GREEN: begin
            ew_w = LAMP_GRN;
            if (tick_w && (tcnt_q == TW'(T_EW - 1)))
               state_d = EW_YELLOW;
         end
         EW_YELLOW: begin
            ew_w = LAMP_YEL;
            if (tick_w && (tcnt_q == TW'(T_YEL - 1)))
               state_d = ALL_RED_2;
         end
         ALL_RED_2: begin
            if (tick_w && (tcnt_q == TW'(T_AR - 1)))
               state_d = NS_GREEN;
         end
         default: begin
            // Illegal codes show all-red and rejoin via the clearance state.
            state_d = ALL_RED_2;
         end
      endcase

      // The state timer restarts on every change. In NS_GREEN it holds at
      // T_NS_MIN-1, so a waiting request is served on the very next tick.
      tcnt_d = tcnt_q;
      if (state_d != state_q)
         tcnt_d = '0;
      else if (tick_w && !((state_q == NS_GREEN) && (tcnt_q == TW'(T_NS_MIN - 1))))
         tcnt_d = tcnt_q + TW'(1);

      // A press on the entry edge is served by this green, so it must not
      // also leave a pending request behind.
      enter_ew = (state_d == EW_GREEN) && (state_q != EW_GREEN);
      pend_d   = enter_ew ? 1'b0 : (pend_q | ped_req);

      if (enter_ew)
         walk_d = pend_q | ped_req;
      else if (state_d == EW_GREEN)
         walk_d = walk_q;
      else
         walk_d = 1'b0;
   end

   assign ns_light = ns_w;
   assign ew_light = ew_w;
   assign walk     = walk_q;
   assign tick     = tick_w;
   assign state_o  = state_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;

   localparam int TD  = 4;
   localparam int TNS = 3;
   localparam int TY  = 2;
   localparam int TA  = 1;
   localparam int TE  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sensor = 1'b0;
   logic       ped = 1'b0;
   logic [2:0] ns_light, ew_light, state_o;
   logic       walk, tick;

   always #5 clk = ~clk;

   intersection_ctrl #(
      .TICK_DIV (TD),
      .T_NS_MIN (TNS),
      .T_YEL    (TY),
      .T_AR     (TA),
      .T_EW     (TE)
   ) dut (
      .clock_100mhz (clk),
      .rst          (rst),
      .sensor_ew    (sensor),
      .ped_req      (ped),
      .ns_light     (ns_light),
      .ew_light     (ew_light),
      .walk         (walk),
      .tick         (tick),
      .state_o      (state_o)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       walk;
      logic       tick;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: phase index plus cycle-based ages.
   int m_phase = 0;
   int m_age   = 0;
   int m_cyc   = 0;
   bit m_pend  = 0;
   bit m_walk  = 0;

   function automatic int dur_ticks(input int ph);
      case (ph)
         0:       return TNS;
         1, 4:    return TY;
         2, 5:    return TA;
         default: return TE;
      endcase
   endfunction

   function automatic logic [2:0] ns_of(input int ph);
      if (ph == 0) return 3'b001;
      if (ph == 1) return 3'b010;
      return 3'b100;
   endfunction

   function automatic logic [2:0] ew_of(input int ph);
      if (ph == 3) return 3'b001;
      if (ph == 4) return 3'b010;
      return 3'b100;
   endfunction

   task automatic model_step(input bit r, input bit s, input bit p);
      bit t, leave, enter;
      int nph;
      if (r) begin
         m_phase = 0; m_age = 0; m_cyc = 0; m_pend = 0; m_walk = 0;
         return;
      end
      t = ((m_cyc % TD) == TD - 1);
      if (m_phase == 0)
         leave = t && (m_age >= TNS * TD - 1) && (s || m_pend);
      else
         leave = (m_age == dur_ticks(m_phase) * TD - 1);
      nph   = leave ? (m_phase + 1) % 6 : m_phase;
      enter = (nph == 3) && (m_phase != 3);
      if (enter) begin
         m_walk = m_pend | p;
         m_pend = 0;
      end else begin
         m_pend = m_pend | p;
         if (nph != 3) m_walk = 0;
      end
      m_age   = leave ? 0 : m_age + 1;
      m_phase = nph;
      m_cyc++;
   endtask

   // Drive one cycle of inputs and queue the response expected after the edge.
   task automatic drive(input bit r, input bit s, input bit p);
      exp_t e;
      @(negedge clk);
      rst = r; sensor = s; ped = p;
      model_step(r, s, p);
      e.st   = 3'(m_phase);
      e.ns   = ns_of(m_phase);
      e.ew   = ew_of(m_phase);
      e.walk = m_walk;
      e.tick = ((m_cyc % TD) == TD - 1);
      sbq.push_back(e);
   endtask

   // Monitor: pops and compares once per clock, shortly after the edge.
   int   mon_cyc = 0;
   exp_t me;
   always @(posedge clk) begin
      #1;
      if (sbq.size() > 0) begin
         me = sbq.pop_front();
         mon_cyc++;
         total++;
         if (state_o !== me.st) begin
            bad++;
            $display("FAIL state_o @%0d: got %0d want %0d", mon_cyc, state_o, me.st);
         end
         total++;
         if (ns_light !== me.ns) begin
            bad++;
            $display("FAIL ns_light @%0d: got %b want %b", mon_cyc, ns_light, me.ns);
         end
         total++;
         if (ew_light !== me.ew) begin
            bad++;
            $display("FAIL ew_light @%0d: got %b want %b", mon_cyc, ew_light, me.ew);
         end
         total++;
         if (walk !== me.walk) begin
            bad++;
            $display("FAIL walk @%0d: got %b want %b", mon_cyc, walk, me.walk);
         end
         total++;
         if (tick !== me.tick) begin
            bad++;
            $display("FAIL tick @%0d: got %b want %b", mon_cyc, tick, me.tick);
         end
         total++;
         if (!$onehot(ns_light) || !$onehot(ew_light) ||
             ((ns_light !== 3'b100) && (ew_light !== 3'b100))) begin
            bad++;
            $display("FAIL lamp_safety @%0d: got ns=%b ew=%b want one-hot, one side red",
                     mon_cyc, ns_light, ew_light);
         end
      end
   end

   initial begin
      int ps, pp;

      // Idle: NS stays green, ticks every TD cycles.
      drive(1, 0, 0); drive(1, 0, 0);
      for (int k = 0; k < 200; k++) drive(0, 0, 0);

      // Sensor held: one full cycle and return to NS_GREEN.
      drive(1, 0, 0);
      for (int k = 0; k < 60; k++) drive(0, 1, 0);

      // Single pedestrian pulse at cycle 20.
      drive(1, 0, 0);
      for (int k = 0; k < 80; k++) drive(0, 0, (k == 20));

      // Pedestrian press on the EW_GREEN entry edge: no second cycle.
      drive(1, 0, 0);
      for (int k = 0; k < 120; k++) drive(0, (k <= 11), (k == 23));

      // Reset in the middle of EW_GREEN.
      drive(1, 0, 0);
      for (int k = 0; k < 70; k++) drive((k == 26), (k < 26), 0);

      // Sensor pulse off a tick: ignored.
      drive(1, 0, 0);
      for (int k = 0; k < 60; k++) drive(0, (k == 13), 0);

      // Randomised segments with varying input densities.
      for (int seg = 0; seg < 8; seg++) begin
         ps = $urandom_range(0, 40);
         pp = $urandom_range(0, 8);
         for (int k = 0; k < 300; k++)
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 99) < ps),
                  ($urandom_range(0, 99) < pp));
      end

      drive(0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
